// File: rtl/ctrl_pipe_chain.sv
// Control-signal pipeline for the CPU: carries the decoded control bundle and destination tag
// through STAGES registered stages, inserts load-use bubbles and produces forwarding selects.
module ctrl_pipe_chain #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 3,
    parameter int unsigned REG_W  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      Clk,
    input  logic                      R,
    input  logic                      hold,
    input  logic                      flush,
    input  logic                      id_valid,
    input  logic [WIDTH-1:0]          id_ctrl,
    input  logic [REG_W-1:0]          id_rd,
    input  logic                      id_rf_en,
    input  logic                      id_load,
    input  logic [REG_W-1:0]          id_rn,
    input  logic [REG_W-1:0]          id_rm,
    input  logic                      id_rn_use,
    input  logic                      id_rm_use,
    output logic [STAGES*WIDTH-1:0]   stage_ctrl,
    output logic [STAGES*REG_W-1:0]   stage_rd,
    output logic [STAGES-1:0]         stage_valid,
    output logic [STAGES-1:0]         stage_rf_en,
    output logic [STAGES-1:0]         stage_load,
    output logic                      stall,
    output logic [1:0]                fwd_a,
    output logic [1:0]                fwd_b,
    output logic [CNT_W-1:0]          stall_count
);

    logic [WIDTH-1:0]  ctrl_q [STAGES];
    logic [WIDTH-1:0]  ctrl_d [STAGES];
    logic [REG_W-1:0]  rd_q   [STAGES];
    logic [REG_W-1:0]  rd_d   [STAGES];
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] rf_en_q, rf_en_d;
    logic [STAGES-1:0] load_q, load_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [STAGES-1:0] live;
    logic              hazard;
    logic              take_id;

    assign live = valid_q & rf_en_q;

    assign hazard = live[0] & load_q[0] & id_valid &
                    ((id_rn_use & (id_rn == rd_q[0])) | (id_rm_use & (id_rm == rd_q[0])));
    assign stall   = hazard & ~flush & ~R;
    assign take_id = id_valid & ~flush & ~stall;

    always_comb begin
        ctrl_d  = ctrl_q;
        rd_d    = rd_q;
        valid_d = valid_q;
        rf_en_d = rf_en_q;
        load_d  = load_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            // Older stages advance even while stalling, so the load leaves stage 0.
            for (int s = 1; s < STAGES; s++) begin
                ctrl_d[s]  = ctrl_q[s-1];
                rd_d[s]    = rd_q[s-1];
                valid_d[s] = valid_q[s-1];
                rf_en_d[s] = rf_en_q[s-1];
                load_d[s]  = load_q[s-1];
            end
            ctrl_d[0]  = take_id ? id_ctrl : '0;
            rd_d[0]    = take_id ? id_rd : '0;
            valid_d[0] = take_id;
            rf_en_d[0] = take_id & id_rf_en;
            load_d[0]  = take_id & id_load;
            if (stall && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (R) begin
            for (int s = 0; s < STAGES; s++) begin
                ctrl_q[s] <= '0;
                rd_q[s]   <= '0;
            end
            valid_q <= '0;
            rf_en_q <= '0;
            load_q  <= '0;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
            rf_en_q <= rf_en_d;
            load_q  <= load_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk oldest to youngest so the youngest match overrides; a load in stage 0 selects the
    // register file because the stall covers it.
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        for (int s = 2; s >= 0; s--) begin
            if (live[s] && id_rn_use && (id_rn == rd_q[s])) begin
                fwd_a = (s == 0 && load_q[0]) ? 2'd0 : 2'(s + 1);
            end
            if (live[s] && id_rm_use && (id_rm == rd_q[s])) begin
                fwd_b = (s == 0 && load_q[0]) ? 2'd0 : 2'(s + 1);
            end
        end
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stage_ctrl[s*WIDTH +: WIDTH] = ctrl_q[s];
            stage_rd[s*REG_W +: REG_W]   = rd_q[s];
        end
        stage_valid = valid_q;
        stage_rf_en = rf_en_q;
        stage_load  = load_q;
        stall_count = cnt_q;
    end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Scoreboard bench for ctrl_pipe_chain: stimulus queues expected values tagged with the cycle
// they are due, a negedge monitor pops and compares them.
module tb_ctrl_pipe_chain;

    localparam int K_S0     = 0;
    localparam int K_S1     = 1;
    localparam int K_S2     = 2;
    localparam int K_VALID  = 3;
    localparam int K_VALID0 = 4;
    localparam int K_STALL  = 5;
    localparam int K_FWDA   = 6;
    localparam int K_FWDB   = 7;
    localparam int K_CNT    = 8;
    localparam int K_CNT4   = 9;
    localparam int K_ALLZ   = 10;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        Clk;
    logic        R, hold, flush, id_valid;
    logic [15:0] id_ctrl;
    logic [3:0]  id_rd, id_rn, id_rm;
    logic        id_rf_en, id_load, id_rn_use, id_rm_use;

    logic [47:0] stage_ctrl, s4_ctrl;
    logic [11:0] stage_rd, s4_rd;
    logic [2:0]  stage_valid, stage_rf_en, stage_load, s4_valid, s4_rf_en, s4_load;
    logic        stall, s4_stall;
    logic [1:0]  fwd_a, fwd_b, s4_fwd_a, s4_fwd_b;
    logic [15:0] stall_count;
    logic [3:0]  s4_count;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    ctrl_pipe_chain #(.WIDTH(16), .STAGES(3), .REG_W(4), .CNT_W(16)) dut (
        .Clk(Clk), .R(R), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_ctrl(id_ctrl), .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_use(id_rn_use), .id_rm_use(id_rm_use),
        .stage_ctrl(stage_ctrl), .stage_rd(stage_rd), .stage_valid(stage_valid),
        .stage_rf_en(stage_rf_en), .stage_load(stage_load), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    ctrl_pipe_chain #(.WIDTH(16), .STAGES(3), .REG_W(4), .CNT_W(4)) dut4 (
        .Clk(Clk), .R(R), .hold(hold), .flush(flush), .id_valid(id_valid),
        .id_ctrl(id_ctrl), .id_rd(id_rd), .id_rf_en(id_rf_en), .id_load(id_load),
        .id_rn(id_rn), .id_rm(id_rm), .id_rn_use(id_rn_use), .id_rm_use(id_rm_use),
        .stage_ctrl(s4_ctrl), .stage_rd(s4_rd), .stage_valid(s4_valid),
        .stage_rf_en(s4_rf_en), .stage_load(s4_load), .stall(s4_stall),
        .fwd_a(s4_fwd_a), .fwd_b(s4_fwd_b), .stall_count(s4_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_S0:     return 32'(stage_ctrl[15:0]);
            K_S1:     return 32'(stage_ctrl[31:16]);
            K_S2:     return 32'(stage_ctrl[47:32]);
            K_VALID:  return 32'(stage_valid);
            K_VALID0: return 32'(stage_valid[0]);
            K_STALL:  return 32'(stall);
            K_FWDA:   return 32'(fwd_a);
            K_FWDB:   return 32'(fwd_b);
            K_CNT:    return 32'(stall_count);
            K_CNT4:   return 32'(s4_count);
            K_ALLZ:   return 32'(|{stage_ctrl, stage_rd, stage_valid, stage_rf_en, stage_load,
                                   stall_count});
            default:  return 32'hdead_beef;
        endcase
    endfunction

    // Monitor: compare every expectation due in this cycle.
    always @(negedge Clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                act = actual(sb[i].kind);
                n_checks++;
                if (act !== sb[i].exp) begin
                    n_errors++;
                    $display("FAIL %s (cycle %0d): got %0h, expected %0h", sb[i].name, cyc, act,
                             sb[i].exp);
                end
                sb.delete(i);
            end
        end
    end

    task automatic chk(input int kind, input logic [31:0] v, input int dly, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        id_valid  = 1'b0;
        id_ctrl   = 16'h0;
        id_rd     = 4'd0;
        id_rf_en  = 1'b0;
        id_load   = 1'b0;
        id_rn     = 4'd0;
        id_rm     = 4'd0;
        id_rn_use = 1'b0;
        id_rm_use = 1'b0;
    endtask

    task automatic issue(input logic [15:0] c, input logic [3:0] rd, input logic rf,
                         input logic ld, input logic [3:0] rn, input logic rnu,
                         input logic [3:0] rm, input logic rmu);
        id_valid  = 1'b1;
        id_ctrl   = c;
        id_rd     = rd;
        id_rf_en  = rf;
        id_load   = ld;
        id_rn     = rn;
        id_rn_use = rnu;
        id_rm     = rm;
        id_rm_use = rmu;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        R = 1'b1; hold = 1'b0; flush = 1'b0;
        idle();
        chk(K_ALLZ, 0, 1, "reset_zero");
        tick(); tick();
        R = 1'b0;

        // Straight flow with a filled pipe before a second reset.
        for (int i = 1; i <= 6; i++) begin
            issue(16'(i), 4'(i), 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
            if (i <= 4) begin
                chk(K_S0, i, 1, "flow_s0");
                chk(K_S1, i, 2, "flow_s1");
                chk(K_S2, i, 3, "flow_s2");
            end
            chk(K_STALL, 0, 0, "flow_nostall");
            tick();
        end
        chk(K_VALID, 7, 0, "pipe_full");
        R = 1'b1;
        idle();
        chk(K_ALLZ, 0, 1, "reset_full_1");
        chk(K_ALLZ, 0, 2, "reset_full_2");
        chk(K_STALL, 0, 2, "reset_stall");
        chk(K_FWDA, 0, 2, "reset_fwda");
        chk(K_FWDB, 0, 2, "reset_fwdb");
        chk(K_CNT, 0, 2, "reset_cnt");
        tick(); tick();
        R = 1'b0;

        // Load-use: one bubble, then forward from stage 1.
        issue(16'h10, 4'd3, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0);
        tick();
        issue(16'h11, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd0, 1'b0);
        chk(K_STALL, 1, 0, "lu_stall");
        chk(K_CNT, 0, 0, "lu_cnt0");
        tick();
        chk(K_STALL, 0, 0, "lu_stall_clear");
        chk(K_FWDA, 2, 0, "lu_fwda");
        chk(K_VALID0, 0, 0, "lu_bubble");
        chk(K_S1, 16'h10, 0, "lu_load_s1");
        chk(K_CNT, 1, 0, "lu_cnt1");
        chk(K_S0, 16'h11, 1, "lu_dep_s0");
        tick();

        // Forward priority.
        issue(16'h21, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h22, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h23, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h24, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1);
        chk(K_FWDB, 1, 0, "fwd_youngest");
        chk(K_STALL, 0, 0, "fwd_nostall");
        tick();
        issue(16'h25, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h26, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        idle(); tick();
        issue(16'h27, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd5, 1'b1);
        chk(K_FWDB, 2, 0, "fwd_s0_bubble");
        chk(K_FWDA, 0, 0, "fwd_r0_bubble");
        tick();
        issue(16'h28, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        idle(); tick();
        idle(); tick();
        issue(16'h29, 4'd0, 1'b0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0);
        chk(K_FWDA, 3, 0, "fwd_s2");
        tick();

        // Flush during a hazard.
        issue(16'h30, 4'd7, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h31, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 4'd0, 1'b0);
        flush = 1'b1;
        chk(K_STALL, 0, 0, "flush_nostall");
        chk(K_CNT, 1, 0, "flush_cnt_a");
        tick();
        flush = 1'b0;
        idle();
        chk(K_VALID0, 0, 0, "flush_bubble");
        chk(K_S1, 16'h30, 0, "flush_load_s1");
        chk(K_CNT, 1, 0, "flush_cnt_b");
        tick();

        // Hold for 3 cycles over a hazard.
        issue(16'h50, 4'd8, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h51, 4'd2, 1'b1, 1'b0, 4'd0, 1'b0, 4'd8, 1'b1);
        hold = 1'b1;
        for (int d = 0; d < 3; d++) begin
            chk(K_STALL, 1, d, "hold_stall");
            chk(K_CNT, 1, d, "hold_cnt");
            chk(K_S0, 16'h50, d + 1, "hold_frozen");
        end
        tick(); tick(); tick();
        hold = 1'b0;
        chk(K_STALL, 1, 0, "hold_release_stall");
        tick();
        chk(K_STALL, 0, 0, "hold_after_stall");
        chk(K_CNT, 2, 0, "hold_after_cnt");
        chk(K_FWDB, 2, 0, "hold_after_fwdb");
        chk(K_VALID0, 0, 0, "hold_after_bubble");
        chk(K_S0, 16'h51, 1, "hold_dep_s0");
        tick();
        idle();

        // Reset in the middle of a held stall.
        issue(16'h60, 4'd9, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        issue(16'h61, 4'd0, 1'b0, 1'b0, 4'd9, 1'b1, 4'd0, 1'b0);
        hold = 1'b1;
        chk(K_STALL, 1, 0, "midrst_stall");
        tick();
        R = 1'b1;
        chk(K_STALL, 0, 0, "midrst_r_gates");
        tick();
        R = 1'b0; hold = 1'b0;
        idle();
        chk(K_ALLZ, 0, 0, "midrst_zero");
        tick();

        // Back-to-back dependent loads; the 4-bit counter saturates.
        issue(16'h70, 4'd1, 1'b1, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0); tick();
        for (int k = 1; k <= 20; k++) begin
            issue(16'h71, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1, 4'd0, 1'b0);
            chk(K_STALL, 1, 0, "b2b_stall");
            tick();
            chk(K_STALL, 0, 0, "b2b_once");
            if (k == 16) chk(K_CNT4, 15, 0, "sat_hold");
            tick();
        end
        chk(K_CNT4, 15, 0, "sat_cnt4");
        chk(K_CNT, 20, 0, "sat_cnt16");
        idle();
        tick(); tick();

        n_checks++;
        if (s4_count !== 4'd15) begin
            n_errors++;
            $display("FAIL final_cnt4: got %0d, expected 15", s4_count);
        end
        n_checks++;
        if (stall_count !== 16'd20) begin
            n_errors++;
            $display("FAIL final_cnt16: got %0d, expected 20", stall_count);
        end
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL final_stall: got %0b, expected 0", stall);
        end
        n_checks++;
        if (stage_valid !== 3'b100) begin
            n_errors++;
            $display("FAIL final_valid: got %0b, expected 100", stage_valid);
        end
        n_checks++;
        if (stage_ctrl[47:32] !== 16'h71) begin
            n_errors++;
            $display("FAIL final_s2: got %0h, expected 71", stage_ctrl[47:32]);
        end

        foreach (sb[i]) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation never checked, due cycle %0d", sb[i].name, sb[i].due);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
